// File: rtl/seven_segment_reader.sv
// seven_segment_reader
//   Recovers hex digits from a multiplexed, active-low 7-segment display bus.
//   Anodes and cathodes are registered once. A pattern is captured into its
//   digit slot after STABLE_CYCLES consecutive identical samples with exactly
//   one anode low.
//
// Ports
//   clk, rst_n      clock, async active-low reset
//   anodes          [NUM_DIGITS] active-low digit enables
//   cathodes        [8] active-low segments, bit7 = dp, bits 6..0 = g..a
//   clear           sync clear of all captured state
//   digits          [4*NUM_DIGITS] decoded nibble per digit
//   digit_valid     [NUM_DIGITS] digit holds a decoded hex value
//   dp              [NUM_DIGITS] captured decimal point, active-high
//   frame_valid     pulse when every digit was captured since the last pulse
//   pattern_error   pulse on a stable, non-blank, non-hex pattern
//   err_digit       [3] digit index of the latest pattern_error

module seven_segment_reader_slot (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_clear,
  input  logic       i_wr,
  input  logic [3:0] i_nib,
  input  logic       i_valid,
  input  logic       i_dp,
  output logic [3:0] o_nib,
  output logic       o_valid,
  output logic       o_dp
);
  logic [3:0] r_nib;
  logic       r_valid;
  logic       r_dp;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_nib   <= '0;
      r_valid <= 1'b0;
      r_dp    <= 1'b0;
    end else if (i_clear) begin
      r_nib   <= '0;
      r_valid <= 1'b0;
      r_dp    <= 1'b0;
    end else if (i_wr) begin
      r_nib   <= i_nib;
      r_valid <= i_valid;
      r_dp    <= i_dp;
    end
  end

  assign o_nib   = r_nib;
  assign o_valid = r_valid;
  assign o_dp    = r_dp;
endmodule

module seven_segment_reader #(
  parameter int NUM_DIGITS    = 8,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_DIGITS-1:0]   anodes,
  input  logic [7:0]              cathodes,
  input  logic                    clear,
  output logic [4*NUM_DIGITS-1:0] digits,
  output logic [NUM_DIGITS-1:0]   digit_valid,
  output logic [NUM_DIGITS-1:0]   dp,
  output logic                    frame_valid,
  output logic                    pattern_error,
  output logic [2:0]              err_digit
);
  typedef enum logic [1:0] {IDLE, TRACK, HOLD} state_t;

  localparam logic [7:0] LP_TGT = 8'(STABLE_CYCLES);

  // {hit, blank, nibble}
  function automatic logic [5:0] f_decode(input logic [6:0] seg);
    logic [5:0] d;
    d = 6'b00_0000;
    case (seg)
      7'h40: d = 6'b10_0000;
      7'h79: d = 6'b10_0001;
      7'h24: d = 6'b10_0010;
      7'h30: d = 6'b10_0011;
      7'h19: d = 6'b10_0100;
      7'h12: d = 6'b10_0101;
      7'h02: d = 6'b10_0110;
      7'h78: d = 6'b10_0111;
      7'h00: d = 6'b10_1000;
      7'h10: d = 6'b10_1001;
      7'h08: d = 6'b10_1010;
      7'h03: d = 6'b10_1011;
      7'h46: d = 6'b10_1100;
      7'h21: d = 6'b10_1101;
      7'h06: d = 6'b10_1110;
      7'h0E: d = 6'b10_1111;
      7'h7F: d = 6'b01_0000;
      default: d = 6'b00_0000;
    endcase
    return d;
  endfunction

  // sample stage and the sample before it; reset to all-ones (nothing selected)
  logic [NUM_DIGITS-1:0] r_s_an, r_p_an;
  logic [7:0]            r_s_cat, r_p_cat;

  state_t                r_state, w_state_nx;
  logic [7:0]            r_cnt, w_cnt_nx;
  logic [NUM_DIGITS-1:0] r_seen;
  logic                  r_frame_valid, r_pattern_error;
  logic [2:0]            r_err_digit;

  logic [3:0]            w_lows;
  logic [2:0]            w_idx;
  logic                  w_sel, w_same, w_cap;
  logic [5:0]            w_dec;
  logic                  w_hit, w_blank;
  logic [3:0]            w_nib;
  logic [NUM_DIGITS-1:0] w_wr, w_seen_nx;

  always_comb begin
    w_lows = '0;
    w_idx  = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      w_lows = w_lows + {3'b000, ~r_s_an[i]};
      if (!r_s_an[i]) w_idx = 3'(i);
    end
  end

  assign w_sel  = (w_lows == 4'd1);
  assign w_same = (r_s_an == r_p_an) && (r_s_cat == r_p_cat);

  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    w_cap      = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_sel) begin
          w_state_nx = TRACK;
          w_cnt_nx   = 8'd1;
        end
      end
      TRACK: begin
        if (w_same) begin
          w_cnt_nx = r_cnt + 8'd1;
          if (r_cnt + 8'd1 == LP_TGT) begin
            w_state_nx = HOLD;
            w_cap      = 1'b1;
          end
        end else if (w_sel) begin
          w_cnt_nx = 8'd1;
        end else begin
          w_state_nx = IDLE;
          w_cnt_nx   = 8'd0;
        end
      end
      HOLD: begin
        if (!w_same) begin
          if (w_sel) begin
            w_state_nx = TRACK;
            w_cnt_nx   = 8'd1;
          end else begin
            w_state_nx = IDLE;
            w_cnt_nx   = 8'd0;
          end
        end
      end
      default: begin
        w_state_nx = IDLE;
        w_cnt_nx   = 8'd0;
      end
    endcase
  end

  assign w_dec     = f_decode(r_s_cat[6:0]);
  assign w_hit     = w_dec[5];
  assign w_blank   = w_dec[4];
  assign w_nib     = w_hit ? w_dec[3:0] : 4'h0;
  // w_sel guarantees a one-hot write strobe on capture
  assign w_wr      = w_cap ? ~r_s_an : '0;
  assign w_seen_nx = r_seen | w_wr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s_an          <= '1;
      r_s_cat         <= '1;
      r_p_an          <= '1;
      r_p_cat         <= '1;
      r_state         <= IDLE;
      r_cnt           <= '0;
      r_seen          <= '0;
      r_frame_valid   <= 1'b0;
      r_pattern_error <= 1'b0;
      r_err_digit     <= '0;
    end else begin
      r_s_an  <= anodes;
      r_s_cat <= cathodes;
      r_p_an  <= r_s_an;
      r_p_cat <= r_s_cat;
      if (clear) begin
        r_state         <= IDLE;
        r_cnt           <= '0;
        r_seen          <= '0;
        r_frame_valid   <= 1'b0;
        r_pattern_error <= 1'b0;
        r_err_digit     <= '0;
      end else begin
        r_state         <= w_state_nx;
        r_cnt           <= w_cnt_nx;
        r_frame_valid   <= w_cap && (&w_seen_nx);
        r_pattern_error <= w_cap && !w_hit && !w_blank;
        if (w_cap && !w_hit && !w_blank) r_err_digit <= w_idx;
        // completing capture pulses the frame and restarts accounting
        if (w_cap && (&w_seen_nx)) r_seen <= '0;
        else                       r_seen <= w_seen_nx;
      end
    end
  end

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_slot
    seven_segment_reader_slot u_slot (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_clear (clear),
      .i_wr    (w_wr[g]),
      .i_nib   (w_nib),
      .i_valid (w_hit),
      .i_dp    (~r_s_cat[7]),
      .o_nib   (digits[4*g +: 4]),
      .o_valid (digit_valid[g]),
      .o_dp    (dp[g])
    );
  end

  assign frame_valid   = r_frame_valid;
  assign pattern_error = r_pattern_error;
  assign err_digit     = r_err_digit;
endmodule

// File: tb/tb_seven_segment_reader.sv
// tb_seven_segment_reader
//   Table-driven directed vectors for seven_segment_reader (8 digits,
//   STABLE_CYCLES=4) plus hand sequences for frame accounting, clear vs
//   capture and async reset during tracking.

module tb_seven_segment_reader;
  logic        clk;
  logic        rst_n;
  logic [7:0]  anodes;
  logic [7:0]  cathodes;
  logic        clear;
  logic [31:0] digits;
  logic [7:0]  digit_valid;
  logic [7:0]  dp;
  logic        frame_valid;
  logic        pattern_error;
  logic [2:0]  err_digit;

  seven_segment_reader #(.NUM_DIGITS(8), .STABLE_CYCLES(4)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .anodes        (anodes),
    .cathodes      (cathodes),
    .clear         (clear),
    .digits        (digits),
    .digit_valid   (digit_valid),
    .dp            (dp),
    .frame_valid   (frame_valid),
    .pattern_error (pattern_error),
    .err_digit     (err_digit)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [7:0]  an;
    logic [7:0]  cat;
    int          n;
    logic [31:0] dig;
    logic [7:0]  vld;
    logic [7:0]  dpx;
    int          fv;
    int          pe;
    logic [2:0]  errd;
  } vec_t;

  vec_t       tv [12];
  logic [6:0] seg [8];
  int         n_chk = 0;
  int         n_fail = 0;
  int         fv_cnt, pe_cnt;
  logic       fv_prev, pe_prev;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // advance n edges; outputs sampled 1 time unit after each edge
  task automatic step(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
      if (frame_valid)   begin fv_cnt++; chk("frame_valid one-cycle", 32'(fv_prev), 32'd0); end
      if (pattern_error) begin pe_cnt++; chk("pattern_error one-cycle", 32'(pe_prev), 32'd0); end
      fv_prev = frame_valid;
      pe_prev = pattern_error;
    end
  endtask

  task automatic drive(input logic [7:0] an, input logic [7:0] cat);
    anodes   = an;
    cathodes = cat;
  endtask

  initial begin
    seg[0] = 7'h40; seg[1] = 7'h79; seg[2] = 7'h24; seg[3] = 7'h30;
    seg[4] = 7'h19; seg[5] = 7'h12; seg[6] = 7'h02; seg[7] = 7'h78;

    //            an     cat    n   digits        vld    dp     fv pe errd
    tv[0]  = '{8'hFE, 8'hA4,  4, 32'h00000000, 8'h00, 8'h00, 0, 0, 3'd0};
    tv[1]  = '{8'hFE, 8'hA4,  1, 32'h00000002, 8'h01, 8'h00, 0, 0, 3'd0};
    tv[2]  = '{8'hFD, 8'h30,  3, 32'h00000002, 8'h01, 8'h00, 0, 0, 3'd0};
    tv[3]  = '{8'hFD, 8'h79,  5, 32'h00000012, 8'h03, 8'h02, 0, 0, 3'd0};
    tv[4]  = '{8'hFB, 8'hD5,  5, 32'h00000012, 8'h03, 8'h02, 0, 1, 3'd2};
    tv[5]  = '{8'hFB, 8'h7F,  5, 32'h00000012, 8'h03, 8'h06, 0, 0, 3'd2};
    // all segments dark is blank regardless of the dp bit
    tv[6]  = '{8'hFB, 8'hFF,  5, 32'h00000012, 8'h03, 8'h02, 0, 0, 3'd2};
    tv[7]  = '{8'hF7, 8'h88,  5, 32'h0000A012, 8'h0B, 8'h02, 0, 0, 3'd2};
    tv[8]  = '{8'hFC, 8'h40, 20, 32'h0000A012, 8'h0B, 8'h02, 0, 0, 3'd2};
    tv[9]  = '{8'hFF, 8'h40,  5, 32'h0000A012, 8'h0B, 8'h02, 0, 0, 3'd2};
    tv[10] = '{8'hEF, 8'h46,  5, 32'h000CA012, 8'h1B, 8'h12, 0, 0, 3'd2};
    tv[11] = '{8'hF7, 8'hD5,  5, 32'h000C0012, 8'h13, 8'h12, 0, 1, 3'd3};

    fv_prev = 1'b0; pe_prev = 1'b0;
    rst_n = 1'b0; clear = 1'b0;
    drive(8'hFF, 8'hFF);
    fv_cnt = 0; pe_cnt = 0;
    step(3);
    chk("reset digits", digits, 32'h0);
    chk("reset digit_valid", 32'(digit_valid), 32'h0);
    chk("reset dp", 32'(dp), 32'h0);
    chk("reset frame_valid", 32'(frame_valid), 32'h0);
    chk("reset pattern_error", 32'(pattern_error), 32'h0);
    chk("reset err_digit", 32'(err_digit), 32'h0);
    rst_n = 1'b1;

    for (int v = 0; v < 12; v++) begin
      drive(tv[v].an, tv[v].cat);
      fv_cnt = 0; pe_cnt = 0;
      step(tv[v].n);
      chk($sformatf("vec%0d digits", v), digits, tv[v].dig);
      chk($sformatf("vec%0d digit_valid", v), 32'(digit_valid), 32'(tv[v].vld));
      chk($sformatf("vec%0d dp", v), 32'(dp), 32'(tv[v].dpx));
      chk($sformatf("vec%0d frame pulses", v), 32'(fv_cnt), 32'(tv[v].fv));
      chk($sformatf("vec%0d error pulses", v), 32'(pe_cnt), 32'(tv[v].pe));
      chk($sformatf("vec%0d err_digit", v), 32'(err_digit), 32'(tv[v].errd));
    end

    // clear wipes captured state
    clear = 1'b1;
    drive(8'hFF, 8'hFF);
    step(1);
    clear = 1'b0;
    chk("clear digits", digits, 32'h0);
    chk("clear digit_valid", 32'(digit_valid), 32'h0);
    chk("clear dp", 32'(dp), 32'h0);
    chk("clear err_digit", 32'(err_digit), 32'h0);

    // full scan 0..7: one frame pulse on the digit-7 capture
    for (int i = 0; i < 8; i++) begin
      drive(~(8'h01 << i), {1'b1, seg[i]});
      fv_cnt = 0;
      step(5);
      chk($sformatf("scan digit%0d frame pulses", i), 32'(fv_cnt), (i == 7) ? 32'd1 : 32'd0);
    end
    chk("scan frame_valid on capture edge", 32'(frame_valid), 32'd1);
    chk("scan digits", digits, 32'h76543210);
    chk("scan digit_valid", 32'(digit_valid), 32'hFF);
    chk("scan dp", 32'(dp), 32'h00);
    step(1);
    chk("scan frame_valid drops", 32'(frame_valid), 32'd0);

    // mask restarted; re-capturing digit 0 must not count twice
    fv_cnt = 0;
    drive(8'hFE, {1'b1, 7'h10}); step(5);
    drive(8'hFE, {1'b1, 7'h00}); step(5);
    for (int i = 1; i < 7; i++) begin
      drive(~(8'h01 << i), {1'b1, seg[i]});
      step(5);
    end
    chk("rescan no early frame", 32'(fv_cnt), 32'd0);
    drive(8'h7F, {1'b1, seg[7]}); step(5);
    chk("rescan frame pulses", 32'(fv_cnt), 32'd1);
    chk("rescan digits", digits, 32'h76543218);

    // clear on the capture edge wins, then a full fresh run is needed
    drive(8'hFE, {1'b1, seg[3]});
    fv_cnt = 0;
    step(4);
    clear = 1'b1;
    step(1);
    clear = 1'b0;
    chk("clear-vs-capture digit_valid", 32'(digit_valid), 32'h0);
    chk("clear-vs-capture digits", digits, 32'h0);
    chk("clear-vs-capture frame pulses", 32'(fv_cnt), 32'd0);
    step(3);
    chk("post-clear no early capture", 32'(digit_valid), 32'h0);
    step(1);
    chk("post-clear capture valid", 32'(digit_valid), 32'h01);
    chk("post-clear capture digits", digits, 32'h00000003);

    // async reset while tracking abandons the pending capture
    drive(8'hFD, {1'b1, seg[4]});
    step(4);
    #2 rst_n = 1'b0;
    #1;
    chk("async reset digits", digits, 32'h0);
    chk("async reset digit_valid", 32'(digit_valid), 32'h0);
    step(2);
    rst_n = 1'b1;
    step(4);
    chk("post-reset no capture at 4", 32'(digit_valid), 32'h0);
    step(1);
    chk("post-reset capture valid", 32'(digit_valid), 32'h02);
    chk("post-reset capture digits", digits, 32'h00000040);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
